// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI response/burst constants, FSM state types and burst helper
package axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
  function automatic logic burst_ok(input logic [1:0] b);
    return b == BURST_FIXED || b == BURST_INCR;
  endfunction
endpackage

// File: rtl/axi_ram_bytewe.sv
// axi_ram_bytewe: read-first simple dual-port RAM with per-byte write enables
module axi_ram_bytewe #(
  parameter int DATA_W = 256,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++)
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave backed by on-chip RAM with independent read/write FSMs
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 256,
  parameter int ID_W       = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  localparam int LSB = $clog2(DATA_W/8);
  w_state_e w_state_q, w_state_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
  logic [7:0] w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [1:0] w_burst_q, w_burst_d, w_resp_q, w_resp_d;
  logic w_err_q, w_err_d;
  r_state_e r_state_q, r_state_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
  logic [7:0] r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [1:0] r_burst_q, r_burst_d, r_resp_q, r_resp_d;
  logic [DATA_W-1:0] ram_rdata;
  logic unused;
  assign unused = ^{s_axi_awsize, s_axi_arsize,
                    s_axi_awaddr[ADDR_W-1:LSB+DEPTH_LOG2], s_axi_awaddr[LSB-1:0],
                    s_axi_araddr[ADDR_W-1:LSB+DEPTH_LOG2], s_axi_araddr[LSB-1:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= '0;
      w_resp_q  <= RESP_OKAY;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_burst_q <= w_burst_d;
      w_resp_q  <= w_resp_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_burst_q <= r_burst_d;
      r_resp_q  <= r_resp_d;
    end
  end
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_burst_d = w_burst_q;
    w_resp_d  = w_resp_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: if (s_axi_awvalid) begin
        w_state_d = W_DATA;
        w_id_d    = s_axi_awid;
        w_idx_d   = s_axi_awaddr[LSB +: DEPTH_LOG2];
        w_len_d   = s_axi_awlen;
        w_beat_d  = '0;
        w_burst_d = s_axi_awburst;
        w_err_d   = !burst_ok(s_axi_awburst);
      end
      W_DATA: if (s_axi_wvalid) begin
        w_idx_d  = w_burst_q == BURST_INCR ? w_idx_q + 1'b1 : w_idx_q;
        w_beat_d = w_beat_q + 8'd1;
        w_err_d  = w_err_q | (s_axi_wlast != (w_beat_q == w_len_q));
        if (w_beat_q == w_len_q) begin
          w_state_d = W_RESP;
          w_resp_d  = w_err_d ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_burst_d = r_burst_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_IDLE: if (s_axi_arvalid) begin
        r_state_d = R_FETCH;
        r_id_d    = s_axi_arid;
        r_idx_d   = s_axi_araddr[LSB +: DEPTH_LOG2];
        r_len_d   = s_axi_arlen;
        r_beat_d  = '0;
        r_burst_d = s_axi_arburst;
        r_resp_d  = burst_ok(s_axi_arburst) ? RESP_OKAY : RESP_SLVERR;
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: if (s_axi_rready) begin
        r_state_d = r_beat_q == r_len_q ? R_IDLE : R_FETCH;
        r_idx_d   = r_burst_q == BURST_INCR ? r_idx_q + 1'b1 : r_idx_q;
        r_beat_d  = r_beat_q + 8'd1;
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  axi_ram_bytewe #(.DATA_W(DATA_W), .AW(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (w_state_q == W_DATA && s_axi_wvalid && burst_ok(w_burst_q)),
    .waddr (w_idx_q),
    .wstrb (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (r_state_q == R_FETCH),
    .raddr (r_idx_q),
    .rdata (ram_rdata)
  );
  assign s_axi_awready = w_state_q == W_IDLE;
  assign s_axi_wready  = w_state_q == W_DATA;
  assign s_axi_bvalid  = w_state_q == W_RESP;
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = w_resp_q;
  assign s_axi_arready = r_state_q == R_IDLE;
  assign s_axi_rvalid  = r_state_q == R_DATA;
  assign s_axi_rlast   = s_axi_rvalid && r_beat_q == r_len_q;
  assign s_axi_rid     = r_id_q;
  assign s_axi_rresp   = r_resp_q;
  assign s_axi_rdata   = s_axi_rvalid && r_resp_q == RESP_OKAY ? ram_rdata : '0;
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed and randomized AXI traffic checked against a word-array model
module tb_axi_ram_slave;
  logic clk, rst_n;
  logic [3:0] awid, arid, bid, rid;
  logic [28:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [255:0] wdata, rdata;
  logic [31:0] wstrb;
  int tests = 0;
  int fails = 0;
  logic [255:0] mem_m [1024];
  bit known [1024];
  logic [255:0] wd [16];
  logic [31:0] ws [16];
  axi_ram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction
  function automatic logic [28:0] mkaddr(input int idx);
    logic [28:0] a;
    a = 29'($urandom());
    a[14:5] = 10'(idx);
    return a;
  endfunction
  function automatic int next_idx(input int idx, input logic [1:0] burst);
    return burst == 2'b01 ? (idx + 1) % 1024 : idx;
  endfunction
  task automatic model_write(input int idx, input logic [255:0] d, input logic [31:0] s);
    logic [255:0] m;
    for (int i = 0; i < 32; i++) m[8*i +: 8] = {8{s[i]}};
    if (known[idx]) mem_m[idx] = (mem_m[idx] & ~m) | (d & m);
    else if (s == 32'hFFFF_FFFF) begin
      mem_m[idx] = d;
      known[idx] = 1'b1;
    end
  endtask
  task automatic do_write(input logic [3:0] id, input int idx, input int len, input logic [1:0] burst,
                          input int bad_beat, input int bstall);
    int ix;
    logic [1:0] exp_resp;
    ix = idx;
    exp_resp = burst[1] ? 2'b10 : 2'b00;
    awvalid = 1'b1; awid = id; awaddr = mkaddr(idx); awlen = 8'(len); awburst = burst;
    awsize = 3'd5;
    check("awready_idle", awready, 1'b1);
    step();
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b];
      wlast = (b == len) ^ (b == bad_beat);
      if (b == bad_beat) exp_resp = 2'b10;
      check("wready_beat", wready, 1'b1);
      check("bvalid_low", bvalid, 1'b0);
      if (!burst[1]) model_write(ix, wd[b], ws[b]);
      ix = next_idx(ix, burst);
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid", bvalid, 1'b1);
    check("bid", bid, id);
    check("bresp", bresp, exp_resp);
    for (int c = 0; c < bstall; c++) begin
      check("awready_busy", awready, 1'b0);
      step();
      check("bvalid_hold", bvalid, 1'b1);
      check("bid_hold", bid, id);
      check("bresp_hold", bresp, exp_resp);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("bvalid_done", bvalid, 1'b0);
    check("awready_back", awready, 1'b1);
  endtask
  task automatic do_read(input logic [3:0] id, input int idx, input int len, input logic [1:0] burst,
                         input int stall_beat, input int stall);
    int ix;
    logic [255:0] exp;
    bit chk;
    ix = idx;
    arvalid = 1'b1; arid = id; araddr = mkaddr(idx); arlen = 8'(len); arburst = burst;
    arsize = 3'd5;
    check("arready_idle", arready, 1'b1);
    step();
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      check("rvalid_fetch", rvalid, 1'b0);
      step();
      chk = burst[1] || known[ix];
      exp = burst[1] ? '0 : mem_m[ix];
      check("rvalid", rvalid, 1'b1);
      check("rid", rid, id);
      check("rlast", rlast, b == len);
      check("rresp", rresp, burst[1] ? 2'b10 : 2'b00);
      if (chk) check("rdata", rdata, exp);
      if (b == stall_beat) begin
        for (int c = 0; c < stall; c++) begin
          step();
          check("rvalid_hold", rvalid, 1'b1);
          if (chk) check("rdata_hold", rdata, exp);
        end
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
      ix = next_idx(ix, burst);
    end
    check("rvalid_done", rvalid, 1'b0);
    check("arready_back", arready, 1'b1);
  endtask
  initial begin
    logic [255:0] va, vb;
    logic [1:0] bt;
    int idx, len, r;
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    #2;
    check("rst_awready", awready, 1'b1);
    check("rst_arready", arready, 1'b1);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_bid", bid, 4'd0);
    check("rst_rid", rid, 4'd0);
    check("rst_rdata", rdata, 256'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_awready", awready, 1'b1);
    wd[0] = {32{8'hA5}}; ws[0] = '1;
    do_write(4'd6, 2, 0, 2'b01, -1, 0);
    do_read(4'd9, 2, 0, 2'b01, -1, 0);
    for (int b = 0; b < 4; b++) begin wd[b] = 256'(b + 1); ws[b] = '1; end
    do_write(4'd1, 5, 3, 2'b01, -1, 0);
    do_read(4'd2, 5, 3, 2'b01, -1, 0);
    wd[0] = '1; ws[0] = '1;
    do_write(4'd3, 7, 0, 2'b01, -1, 0);
    wd[0] = '0; ws[0] = 32'h0000_000F;
    do_write(4'd3, 7, 0, 2'b01, -1, 0);
    check("strb_model", mem_m[7], {{224{1'b1}}, 32'd0});
    do_read(4'd4, 7, 0, 2'b00, -1, 0);
    wd[0] = rnd256(); ws[0] = '1;
    do_write(4'd12, 8, 0, 2'b01, -1, 5);
    do_read(4'd5, 5, 3, 2'b01, 1, 4);
    wd[0] = rnd256(); wd[1] = rnd256(); ws[0] = '1; ws[1] = '1;
    do_write(4'd7, 9, 0, 2'b01, -1, 0);
    do_write(4'd8, 9, 1, 2'b10, -1, 0);
    do_read(4'd8, 9, 0, 2'b01, -1, 0);
    do_read(4'd10, 9, 1, 2'b10, -1, 0);
    wd[0] = rnd256(); wd[1] = rnd256();
    do_write(4'd11, 1023, 1, 2'b01, -1, 0);
    check("wrap_model", mem_m[0], wd[1]);
    do_read(4'd11, 1023, 1, 2'b01, -1, 0);
    do_read(4'd11, 0, 0, 2'b01, -1, 0);
    do_write(4'd13, 10, 1, 2'b01, 0, 0);
    do_write(4'd14, 12, 1, 2'b00, 1, 0);
    va = rnd256(); vb = rnd256();
    wd[0] = va; ws[0] = '1;
    do_write(4'd1, 30, 0, 2'b01, -1, 0);
    awvalid = 1'b1; awid = 4'd2; awaddr = mkaddr(30); awlen = 8'd0; awburst = 2'b01;
    arvalid = 1'b1; arid = 4'd3; araddr = mkaddr(30); arlen = 8'd0; arburst = 2'b01;
    check("cc_awready", awready, 1'b1);
    check("cc_arready", arready, 1'b1);
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    wvalid = 1'b1; wdata = vb; wstrb = '1; wlast = 1'b1;
    check("cc_wready", wready, 1'b1);
    check("cc_rvalid_fetch", rvalid, 1'b0);
    step();
    wvalid = 1'b0; wlast = 1'b0;
    check("cc_rvalid", rvalid, 1'b1);
    check("cc_old_data", rdata, va);
    check("cc_bvalid", bvalid, 1'b1);
    check("cc_bresp", bresp, 2'b00);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    mem_m[30] = vb;
    do_read(4'd3, 30, 0, 2'b01, -1, 0);
    awvalid = 1'b1; awid = 4'd5; awaddr = mkaddr(20); awlen = 8'd3; awburst = 2'b01;
    step();
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wd[b] = rnd256();
      wvalid = 1'b1; wdata = wd[b]; wstrb = '1; wlast = 1'b0;
      model_write(20 + b, wd[b], '1);
      step();
    end
    rst_n = 1'b0;
    wvalid = 1'b0;
    #1;
    check("mid_rst_wready", wready, 1'b0);
    check("mid_rst_awready", awready, 1'b1);
    check("mid_rst_bvalid", bvalid, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    wd[0] = rnd256(); ws[0] = '1;
    do_write(4'd6, 25, 0, 2'b01, -1, 0);
    do_read(4'd6, 20, 1, 2'b01, -1, 0);
    do_read(4'd6, 25, 0, 2'b01, -1, 0);
    for (int t = 0; t < 30; t++) begin
      idx = ($urandom_range(0, 1) ? 1020 : 40) + $urandom_range(0, 3);
      len = $urandom_range(0, 3);
      r = $urandom_range(0, 7);
      bt = r < 3 ? 2'b01 : r < 5 ? 2'b00 : r == 5 ? 2'b10 : r == 6 ? 2'b11 : 2'b01;
      for (int b = 0; b <= len; b++) begin
        wd[b] = rnd256();
        ws[b] = $urandom_range(0, 2) != 0 ? 32'hFFFF_FFFF : $urandom();
      end
      do_write(4'($urandom()), idx, len,  bt, $urandom_range(0, 5) == 0 ? $urandom_range(0, len) : -1,
               $urandom_range(0, 2));
      idx = ($urandom_range(0, 1) ? 1020 : 40) + $urandom_range(0, 3);
      len = $urandom_range(0, 3);
      r = $urandom_range(0, 7);
      bt = r < 4 ? 2'b01 : r < 6 ? 2'b00 : r == 6 ? 2'b10 : 2'b11;
      do_read(4'($urandom()), idx, len, bt, $urandom_range(0, len), $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
